// File: rtl/mem_port_arbiter.sv
// Shares one code/data memory port between the fetch and load/store requesters; data has priority.
// Defining MEM_ARB_STARVE_GUARD_EN adds a data-grant streak counter that forces a fetch grant.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic              mem_ir_dr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_ir,
    input  logic [DATA_W-1:0] mem_dr,
    output logic              busy,
    output logic              gnt_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              gnt_data_q, gnt_data_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_ir_dr_q, mem_ir_dr_d;
    logic              f_ack_q, f_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic elig_d, elig_f, grant, sel_data;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned STREAK_W =
        ($clog2(MAX_STREAK + 1) > 3) ? $clog2(MAX_STREAK + 1) : 3;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;
`else
    // MAX_STREAK only shapes the guarded build.
    logic unused_max_streak;
    assign unused_max_streak = ^MAX_STREAK;
`endif

    // Arbitration: the requester being acked in RESP is not eligible that cycle.
    always_comb begin
        elig_d = d_req;
        elig_f = f_req;
        if (state_q == RESP) begin
            if (gnt_data_q) begin
                elig_d = 1'b0;
            end else begin
                elig_f = 1'b0;
            end
        end
        grant    = (state_q != ISSUE) && (elig_d || elig_f);
        sel_data = elig_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
        if (elig_d && elig_f && (streak_q == STREAK_MAX)) begin
            sel_data = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        gnt_data_d  = gnt_data_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE, RESP: state_d = grant ? ISSUE : IDLE;
            ISSUE:      state_d = RESP;
            default:    state_d = IDLE;
        endcase

        if (grant) begin
            gnt_data_d = sel_data;
            we_d       = sel_data & d_we;
            mem_addr_d = sel_data ? d_addr : f_addr;
            if (sel_data) begin
                mem_wdata_d = d_wdata;
            end
        end

        // Memory strobes are registered so they are live exactly during ISSUE.
        mem_wr_d    = ~(grant & sel_data & d_we);
        mem_ir_dr_d = grant & sel_data;
        f_ack_d     = (state_q == ISSUE) & ~gnt_data_q;
        d_ack_d     = (state_q == ISSUE) & gnt_data_q;
        busy_d      = (state_d != IDLE);

        // Memory read data arrives only in RESP, so it bypasses the hold register then.
        f_rdata   = f_ack_q ? mem_ir : f_rdata_q;
        d_rdata   = (d_ack_q && !we_q) ? mem_dr : d_rdata_q;
        f_rdata_d = f_rdata;
        d_rdata_d = d_rdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
        streak_d = streak_q;
        if (!f_req) begin
            streak_d = '0;
        end else if (grant && !sel_data) begin
            streak_d = '0;
        end else if (grant && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_data_q  <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b1;
            mem_ir_dr_q <= 1'b0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
            streak_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_data_q  <= gnt_data_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_q    <= mem_wr_d;
            mem_ir_dr_q <= mem_ir_dr_d;
            f_ack_q     <= f_ack_d;
            d_ack_q     <= d_ack_d;
            busy_q      <= busy_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
            streak_q    <= streak_d;
`endif
        end
    end

    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_ir_dr = mem_ir_dr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign gnt_data  = gnt_data_q;

endmodule
